// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALUOp codes and datapath mux-select codes.
// No logic; constants and types only.
package core_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source A
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU source B
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Memory address mux
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_fsm_instr_dec.sv
// Purpose: opcode -> immediate format select for the immediate extender.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
// Ports: op (instruction opcode) in, imm_src (immediate format) out.
module instr_dec
  import core_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;  // lw, I-type ALU, R-type and undefined opcodes
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Purpose: main control FSM of the multicycle RV32I core (FETCH..WB sequencing).
// Latency: Moore outputs from state; imm_src (from op) and pc_write (zero/mem_ready) combinational.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
// Ports: clk, reset_n (async, active low), op, zero, mem_ready in;
//        pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//        alu_src_b, imm_src, alu_op, reg_write, illegal out.
module multicycle_ctrl_fsm
  import core_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal
);

  state_t state, state_nxt;

  // Raw strobes before reset gating
  logic pc_update, branch, ir_wr, mem_wr, reg_wr;

  instr_dec u_instr_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  // Next state. op is only looked at in DECODE and MEMADR, where the IR is stable.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECUTER;
          OP_I:         state_nxt = EXECUTEI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
          default:      state_nxt = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_nxt = MEMWB;
      MEMWB:    state_nxt = FETCH;
      MEMWRITE: if (mem_ready) state_nxt = FETCH;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      ALUWB:    state_nxt = FETCH;
      BEQ:      state_nxt = FETCH;
      JAL:      state_nxt = ALUWB;
      TRAP:     state_nxt = TRAP;   // absorbing until reset
      default:  state_nxt = FETCH;
    endcase
  end

  // Moore output decode
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    adr_src    = ADR_PC;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        ir_wr      = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        // Precompute branch target OldPC + imm into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        adr_src    = ADR_ALUOUT;
        result_src = RES_ALUOUT;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_wr     = 1'b1;
      end
      MEMWRITE: begin
        // Write strobe held until memory accepts it
        adr_src    = ADR_ALUOUT;
        result_src = RES_ALUOUT;
        mem_wr     = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_wr     = 1'b1;
      end
      BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      JAL: begin
        // ALUResult = OldPC + 4 is the link value; ALUOut (target) goes to PC
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
      default: ;  // TRAP: everything at defaults
    endcase
  end

  // Strobes are gated by reset_n so an asserted reset kills any in-flight
  // write in the same cycle rather than at the next clock edge.
  assign pc_write  = reset_n & (pc_update | (branch & zero));
  assign ir_write  = reset_n & ir_wr;
  assign mem_write = reset_n & mem_wr;
  assign reg_write = reset_n & reg_wr;
  assign illegal   = (state == TRAP);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (trap on / trap off) share inputs.
// Expected per-cycle output vectors come from an instruction-level cycle model and
// are queued by the driver; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       zero, mem_ready;

  logic       pc_write_t, adr_src_t, mem_write_t, ir_write_t, reg_write_t, illegal_t;
  logic [1:0] result_src_t, alu_src_a_t, alu_src_b_t, imm_src_t, alu_op_t;
  logic       pc_write_n, adr_src_n, mem_write_n, ir_write_n, reg_write_n, illegal_n;
  logic [1:0] result_src_n, alu_src_a_n, alu_src_b_n, imm_src_n, alu_op_n;

  multicycle_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut_t (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_t), .adr_src(adr_src_t), .mem_write(mem_write_t),
    .ir_write(ir_write_t), .result_src(result_src_t), .alu_src_a(alu_src_a_t),
    .alu_src_b(alu_src_b_t), .imm_src(imm_src_t), .alu_op(alu_op_t),
    .reg_write(reg_write_t), .illegal(illegal_t)
  );

  multicycle_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .adr_src(adr_src_n), .mem_write(mem_write_n),
    .ir_write(ir_write_n), .result_src(result_src_n), .alu_src_a(alu_src_a_n),
    .alu_src_b(alu_src_b_n), .imm_src(imm_src_n), .alu_op(alu_op_n),
    .reg_write(reg_write_n), .illegal(illegal_n)
  );

  always #5 clk = ~clk;

  // Vector: {illegal, pc_write, adr_src, mem_write, ir_write, reg_write,
  //          result_src, alu_src_a, alu_src_b, imm_src, alu_op}
  logic [15:0] got_t, got_n;
  assign got_t = {illegal_t, pc_write_t, adr_src_t, mem_write_t, ir_write_t, reg_write_t,
                  result_src_t, alu_src_a_t, alu_src_b_t, imm_src_t, alu_op_t};
  assign got_n = {illegal_n, pc_write_n, adr_src_n, mem_write_n, ir_write_n, reg_write_n,
                  result_src_n, alu_src_a_n, alu_src_b_n, imm_src_n, alu_op_n};

  typedef struct packed {
    logic [15:0] e_t;
    logic [15:0] e_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] mk(input logic ill, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] im,
                                     input logic [1:0] aop);
    return {ill, pcw, adr, mw, irw, rw, rs, sa, sb, im, aop};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic rb();
    logic b;
    b = 1'($urandom_range(1, 0));
    return b;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: one expected entry per driven cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("seq_trap_on", got_t, e.e_t);
      chk("seq_trap_off", got_n, e.e_n);
    end
  end

  task automatic drive_cycle(input logic [6:0] o, input logic mr, input logic z,
                             input logic [15:0] et, input logic [15:0] en);
    exp_t e;
    @(posedge clk);
    #1;
    op        = o;
    mem_ready = mr;
    zero      = z;
    e.e_t     = et;
    e.e_n     = en;
    exp_q.push_back(e);
  endtask

  // Cycle whose outputs do not depend on mem_ready/zero
  task automatic ex(input logic [6:0] o, input logic [15:0] v);
    drive_cycle(o, rb(), rb(), v, v);
  endtask

  task automatic do_fetch(input logic [6:0] o, input int fw);
    logic [15:0] wv, av;
    wv = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm_of(o), 2'b00);
    av = mk(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm_of(o), 2'b00);
    for (int i = 0; i < fw; i++) drive_cycle(o, 1'b0, rb(), wv, wv);
    drive_cycle(o, 1'b1, rb(), av, av);
  endtask

  task automatic do_decode(input logic [6:0] o);
    ex(o, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm_of(o), 2'b00));
  endtask

  task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input logic bz);
    logic [1:0]  im;
    logic [15:0] v, wb;
    im = imm_of(o);
    wb = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 2'b00);
    do_fetch(o, fw);
    do_decode(o);
    if (o == LW || o == SW) begin
      ex(o, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 2'b00));
      v = mk(0, 0, 1, (o == SW), 0, 0, 2'b00, 2'b00, 2'b00, im, 2'b00);
      for (int i = 0; i < mw; i++) drive_cycle(o, 1'b0, rb(), v, v);
      drive_cycle(o, 1'b1, rb(), v, v);
      if (o == LW) ex(o, mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 2'b00));
    end else if (o == RT) begin
      ex(o, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 2'b10));
      ex(o, wb);
    end else if (o == IT) begin
      ex(o, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 2'b10));
      ex(o, wb);
    end else if (o == BQ) begin
      v = mk(0, bz, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 2'b01);
      drive_cycle(o, rb(), bz, v, v);
    end else if (o == JL) begin
      ex(o, mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 2'b00));
      ex(o, wb);
    end
  endtask

  logic [6:0]  ops [6];
  logic [15:0] fetch_sel_sw, trapv, fa0, dec0, fw0;

  initial begin
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL;

    // Reset state: strobes gated even with mem_ready=1 in FETCH
    reset_n   = 1'b0;
    op        = JL;
    zero      = 1'b1;
    mem_ready = 1'b1;
    #3;
    chk("reset_trap_on", got_t, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00));
    chk("reset_trap_off", got_n, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00));
    @(posedge clk);
    #1;
    chk("reset_held", got_t, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00));
    reset_n   = 1'b1;
    mem_ready = 1'b0;

    // Directed instructions
    run_instr(RT, 0, 0, 1'b0);
    run_instr(LW, 1, 2, 1'b0);
    run_instr(BQ, 0, 0, 1'b1);
    run_instr(BQ, 2, 0, 1'b0);
    run_instr(JL, 0, 0, 1'b0);
    run_instr(IT, 0, 0, 1'b0);
    run_instr(SW, 1, 3, 1'b0);

    // Reset asserted while MEMWRITE is waiting on memory
    do_fetch(SW, 0);
    do_decode(SW);
    ex(SW, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00));
    drive_cycle(SW, 1'b0, rb(), mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00),
                mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mw_memwrite", {15'd0, mem_write_t}, 16'd0);
    fetch_sel_sw = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00);
    chk("rst_mid_mw_trap_on", got_t, fetch_sel_sw);
    chk("rst_mid_mw_trap_off", got_n, fetch_sel_sw);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    run_instr(RT, 2, 0, 1'b0);

    // Randomised instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(5, 0)], $urandom_range(2, 0), $urandom_range(3, 0), rb());
    end

    // Illegal opcode: trap-on instance sticks in TRAP, trap-off refetches
    do_fetch(BAD, 0);
    do_decode(BAD);
    trapv = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    fa0   = mk(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    dec0  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
    fw0   = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    drive_cycle(BAD, 1'b1, rb(), trapv, fa0);
    drive_cycle(BAD, rb(), rb(), trapv, dec0);
    for (int i = 0; i < 98; i++) drive_cycle(BAD, 1'b0, rb(), trapv, fw0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
